// File: rtl/adder_tree_pkg.sv
// Shared constants, stage-count helpers and the per-stage sideband record
// for the adder-tree multiplier pipeline.
package adder_tree_pkg;

    // Widest tag a stage record can carry; narrower tags use the low bits.
    localparam int TAG_W_MAX = 32;

    function automatic int tree_levels(input int n);
        int lvl;
        int span;
        lvl  = 0;
        span = 1;
        while (span < n) begin
            span = span * 2;
            lvl  = lvl + 1;
        end
        return lvl;
    endfunction

    function automatic int pipe_latency(input int n);
        return 1 + tree_levels(n);
    endfunction

    typedef struct packed {
        logic                 valid;
        logic                 sgn;
        logic [TAG_W_MAX-1:0] tag;
    } stage_rec_t;

endpackage

// File: rtl/adder_tree_mult_pipe_pp_gen.sv
// Partial-product generator: AND array, with Baugh-Wooley inversion and
// correction constant when built with ATM_SIGNED_EN.
module atm_pp_gen #(
    parameter int N = 8
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           sgn,
    output logic [2*N-1:0] pp [N]
);

`ifdef ATM_SIGNED_EN
    logic inv_en;
    assign inv_en = sgn;
`else
    logic inv_en;
    logic sgn_unused;
    assign sgn_unused = sgn;
    assign inv_en     = 1'b0;
`endif

    logic [2*N-1:0] row;

    always_comb begin
        row = '0;
        for (int j = 0; j < N; j++) begin
            row = '0;
            for (int i = 0; i < N; i++) begin
                row[i] = a[i] & b[j];
                // Cross terms with exactly one sign bit are inverted.
                if (inv_en && ((i == N - 1) != (j == N - 1))) begin
                    row[i] = ~row[i];
                end
            end
            pp[j] = row << j;
        end
        // Correction 2^N + 2^(2N-1) fits in the unused upper bits of row 0.
        if (inv_en) begin
            pp[0][N]       = 1'b1;
            pp[0][2*N-1]   = 1'b1;
        end
    end

endmodule

// File: rtl/adder_tree_mult_pipe.sv
// Pipelined NxN multiplier: input register, partial products, registered
// binary adder tree. Signed (Baugh-Wooley) mode enabled by ATM_SIGNED_EN.
module adder_tree_mult_pipe
    import adder_tree_pkg::*;
#(
    parameter int N     = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     Data_in_A,
    input  logic [N-1:0]     Data_in_B,
    input  logic             Sgn,
    input  logic [TAG_W-1:0] Tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   P_out,
    output logic [TAG_W-1:0] Tag_out
);

    localparam int LEVELS = tree_levels(N);

    logic           stall;
    logic           accept;
    logic           sgn_in;
    logic           ready_d, ready_q;
    logic [N-1:0]   a_d, a_q;
    logic [N-1:0]   b_d, b_q;
    stage_rec_t     in_rec_d, in_rec_q;
    logic [2*N-1:0] pp [N];

`ifdef ATM_SIGNED_EN
    assign sgn_in = Sgn;
`else
    logic sgn_port_unused;
    assign sgn_port_unused = Sgn;
    assign sgn_in          = 1'b0;
`endif

    // Handshake: a transfer happens on an edge where valid and ready are both 1;
    // the whole pipe freezes while a result waits for out_ready.
    always_comb begin
        stall    = out_valid & ~out_ready;
        in_ready = ready_q & ~stall;
        accept   = in_valid & in_ready;
        ready_d  = 1'b1;
        a_d      = a_q;
        b_d      = b_q;
        in_rec_d = in_rec_q;
        if (!stall) begin
            in_rec_d       = '0;
            in_rec_d.valid = accept;
            if (accept) begin
                a_d                     = Data_in_A;
                b_d                     = Data_in_B;
                in_rec_d.sgn            = sgn_in;
                in_rec_d.tag[TAG_W-1:0] = Tag_in;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            ready_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            in_rec_q <= '0;
        end else begin
            ready_q  <= ready_d;
            a_q      <= a_d;
            b_q      <= b_d;
            in_rec_q <= in_rec_d;
        end
    end

    atm_pp_gen #(.N(N)) u_pp_gen (
        .a   (a_q),
        .b   (b_q),
        .sgn (in_rec_q.sgn),
        .pp  (pp)
    );

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int CNT = N >> (l + 1);

        logic [2*N-1:0] sum_d [CNT];
        logic [2*N-1:0] sum_q [CNT];
        stage_rec_t     rec_d, rec_q;

        if (l == 0) begin : g_first
            always_comb begin
                rec_d = in_rec_q;
                for (int k = 0; k < CNT; k++) begin
                    sum_d[k] = pp[2*k] + pp[2*k+1];
                end
            end
        end else begin : g_rest
            always_comb begin
                rec_d = g_lvl[l-1].rec_q;
                for (int k = 0; k < CNT; k++) begin
                    sum_d[k] = g_lvl[l-1].sum_q[2*k] + g_lvl[l-1].sum_q[2*k+1];
                end
            end
        end

        always_ff @(posedge clk or negedge Reset) begin
            if (!Reset) begin
                rec_q <= '0;
                for (int k = 0; k < CNT; k++) begin
                    sum_q[k] <= '0;
                end
            end else if (!stall) begin
                rec_q <= rec_d;
                for (int k = 0; k < CNT; k++) begin
                    sum_q[k] <= sum_d[k];
                end
            end
        end
    end

    assign out_valid = g_lvl[LEVELS-1].rec_q.valid;
    assign P_out     = g_lvl[LEVELS-1].sum_q[0];
    assign Tag_out   = g_lvl[LEVELS-1].rec_q.tag[TAG_W-1:0];

    logic tail_unused;
    assign tail_unused = ^{g_lvl[LEVELS-1].rec_q.sgn, g_lvl[LEVELS-1].rec_q.tag};

endmodule

// File: tb/tb_adder_tree_mult_pipe.sv
// Self-checking bench for adder_tree_mult_pipe (N=8, TAG_W=4); follows
// ATM_SIGNED_EN to choose signed or unsigned expectations.
module tb_adder_tree_mult_pipe;

    localparam int N     = 8;
    localparam int TAG_W = 4;
`ifdef ATM_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             Reset;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     A;
    logic [N-1:0]     B;
    logic             Sgn;
    logic [TAG_W-1:0] Tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   P_out;
    logic [TAG_W-1:0] Tag_out;

    int checks = 0;
    int errors = 0;
    logic [TAG_W+2*N-1:0] exp_q[$];

    always #5 clk = ~clk;

    adder_tree_mult_pipe #(.N(N), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Data_in_A (A),
        .Data_in_B (B),
        .Sgn       (Sgn),
        .Tag_in    (Tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P_out     (P_out),
        .Tag_out   (Tag_out)
    );

    // Reference product from plain integer arithmetic.
    function automatic logic [2*N-1:0] model_prod(input logic [N-1:0] a,
                                                  input logic [N-1:0] b,
                                                  input logic s);
        longint sa, sb, p;
        if (s && SIGNED_EN) begin
            sa = {{(64-N){a[N-1]}}, a};
            sb = {{(64-N){b[N-1]}}, b};
        end else begin
            sa = {{(64-N){1'b0}}, a};
            sb = {{(64-N){1'b0}}, b};
        end
        p = sa * sb;
        return p[2*N-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: samples on the falling edge, between active edges.
    always @(negedge clk) begin
        if (!Reset) begin
            exp_q.delete();
            check("reset_out_valid", 32'(out_valid), 32'd0);
            check("reset_in_ready", 32'(in_ready), 32'd0);
            check("reset_p_out", 32'(P_out), 32'd0);
            check("reset_tag_out", 32'(Tag_out), 32'd0);
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got tag %0h p %0h expected no result (t=%0t)",
                             Tag_out, P_out, $time);
                end else begin
                    check("sb_product", 32'(P_out), 32'(exp_q[0][2*N-1:0]));
                    check("sb_tag", 32'(Tag_out), 32'(exp_q[0][TAG_W+2*N-1:2*N]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back({Tag_in, model_prod(A, B, Sgn)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic s, input logic [TAG_W-1:0] tag);
        logic acc;
        int   guard;
        A = a; B = b; Sgn = s; Tag_in = tag; in_valid = 1'b1;
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 64) begin
            acc = in_ready;
            step();
            guard++;
        end
        check("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic run_one(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                           input logic [TAG_W-1:0] tag, input logic [2*N-1:0] exp_p,
                           input string name);
        int lat;
        send(a, b, s, tag);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 32) begin
            step();
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd4);
        check({name, "_product"}, 32'(P_out), 32'(exp_p));
        check({name, "_tag"}, 32'(Tag_out), 32'(tag));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 100) begin
            step();
            guard++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    logic [N-1:0] va [6] = '{8'h00, 8'h01, 8'h80, 8'h7F, 8'h55, 8'hC3};
    logic [N-1:0] vb [6] = '{8'h00, 8'hFF, 8'h02, 8'h7F, 8'hAA, 8'h3C};
    logic         vs [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        Reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Sgn = 1'b0; Tag_in = '0;
        repeat (3) step();
        check("por_in_ready", 32'(in_ready), 32'd0);
        check("por_out_valid", 32'(out_valid), 32'd0);
        Reset = 1'b1;
        check("release_in_ready_before_edge", 32'(in_ready), 32'd0);
        step();
        check("release_in_ready_after_edge", 32'(in_ready), 32'd1);

        run_one(8'd3, 8'd5, 1'b0, 4'd1, 16'd15, "basic");
        run_one(8'd255, 8'd255, 1'b0, 4'd2, 16'hFE01, "umax");
        run_one(8'h80, 8'h7F, 1'b1, 4'd3, SIGNED_EN ? 16'hC080 : 16'h3F80, "s_min_max");
        run_one(8'hFF, 8'hFF, 1'b1, 4'd4, SIGNED_EN ? 16'h0001 : 16'hFE01, "s_m1_m1");

        for (int i = 0; i < 6; i++) send(va[i], vb[i], vs[i], 4'(i));
        in_valid = 1'b0;
        drain();

        // Back-pressure: four fill the pipe, then everything freezes.
        out_ready = 1'b0;
        for (int t = 0; t < 4; t++) send(8'(10 + t), 8'(3 + t), 1'b0, 4'(t));
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_first_tag", 32'(Tag_out), 32'd0);
        check("bp_first_product", 32'(P_out), 32'd30);
        A = 8'd14; B = 8'd7; Sgn = 1'b0; Tag_in = 4'd4; in_valid = 1'b1;
        repeat (3) begin
            step();
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_product", 32'(P_out), 32'd30);
            check("bp_hold_tag", 32'(Tag_out), 32'd0);
        end
        out_ready = 1'b1;
        for (int t = 4; t < 8; t++) send(8'(10 + t), 8'(3 + t), 1'b0, 4'(t));
        in_valid = 1'b0;
        drain();

        // Reset with three operations in flight, before any emerges.
        for (int t = 0; t < 3; t++) send(8'(20 + t), 8'd2, 1'b0, 4'(8 + t));
        in_valid = 1'b0;
        Reset = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_p_out", 32'(P_out), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        step();
        Reset = 1'b1;
        check("midrst_release_in_ready", 32'(in_ready), 32'd0);
        step();
        check("midrst_ready_back", 32'(in_ready), 32'd1);
        repeat (6) step();
        run_one(8'd7, 8'd9, 1'b0, 4'd5, 16'd63, "post_reset");

        // Mixed mode back to back on FF x 02.
        for (int t = 0; t < 8; t++) send(8'hFF, 8'h02, 1'(t % 2), 4'(t));
        in_valid = 1'b0;
        check("mixed_valid", 32'(out_valid), 32'd1);
        check("mixed_tag4", 32'(Tag_out), 32'd4);
        check("mixed_unsigned", 32'(P_out), 32'h01FE);
        step();
        check("mixed_tag5", 32'(Tag_out), 32'd5);
        check("mixed_signed", 32'(P_out), SIGNED_EN ? 32'hFFFE : 32'h01FE);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/adder_tree_mult_pipe.md
ADDER_TREE_MULT_PIPE -- requirements
Module: adder_tree_mult_pipe

Interface
REQ-001 SHALL have parameter N, default 8, operand width; legal values 4, 8, 16, 32.
REQ-002 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operands and tag valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts an operation this cycle.
REQ-007 SHALL have port Data_in_A  input  N  multiplicand.
REQ-008 SHALL have port Data_in_B  input  N  multiplier.
REQ-009 SHALL have port Sgn  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 SHALL have port Tag_in  input  TAG_W  sideband tag, returned unchanged with the result.
REQ-011 SHALL have port out_valid  output  1  P_out and Tag_out valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result this cycle.
REQ-013 SHALL have port P_out  output  2N  product.
REQ-014 SHALL have port Tag_out  output  TAG_W  tag of the current result.

Function
REQ-015 An operation SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-016 A result SHALL be consumed on a rising edge where out_valid and out_ready are both 1.
REQ-017 Pipeline structure:
- input register stage;
- N partial products generated combinationally from the registered operands;
- binary adder tree of LOG2(N) levels, each level registered.
REQ-018 Latency SHALL be exactly 1+LOG2(N) cycles from acceptance to out_valid when never stalled (4 cycles for N=8).
REQ-019 Each pipeline stage SHALL carry a valid bit, the tag and the mode bit alongside its data.
REQ-020 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-021 Stall SHALL equal out_valid AND NOT out_ready; while stalled, every stage register SHALL hold its value.
REQ-022 in_ready SHALL equal NOT stall (combinational from out_ready).
REQ-023 Bubbles (valid=0 stages) SHALL NOT be compressed during a stall; only a global stall is required.
REQ-024 Results SHALL emerge in acceptance order, each with its own Tag_in value.
REQ-025 Unsigned mode: P_out SHALL equal A*B, zero-extended to 2N bits, exact with no overflow.
REQ-026 Signed mode: P_out SHALL equal the exact 2N-bit two's-complement product, using Baugh-Wooley partial-product inversion plus correction constant.
REQ-027 Sgn SHALL be captured per operation at acceptance and SHALL NOT affect operations already in flight.
REQ-028 P_out and Tag_out SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-029 Asserting Reset low SHALL immediately clear all stage valid bits, so out_valid=0.
REQ-030 Asserting Reset low SHALL immediately clear P_out and Tag_out to 0.
REQ-031 While Reset is low, in_ready SHALL be 0.
REQ-032 Operations in flight at reset SHALL be discarded and never reported.
REQ-033 in_ready SHALL return to 1 on the first clock edge after Reset deasserts.

Configuration
REQ-034 Macro ATM_SIGNED_EN defined: signed mode SHALL be supported per REQ-026.
REQ-035 Macro ATM_SIGNED_EN undefined: the Sgn port SHALL remain present but be ignored, all operations SHALL be unsigned, and the signed-correction logic SHALL be absent.

Structure
REQ-036 Package adder_tree_pkg SHALL hold:
- the LOG2 stage-count function;
- the latency constant expression;
- the stage-record typedef (valid, sgn, tag).
REQ-037 Sub-module atm_pp_gen SHALL generate the N partial products (AND array with optional Baugh-Wooley inversion); all registers SHALL stay in adder_tree_mult_pipe.

Verification (N=8, TAG_W=4)
REQ-038 Unsigned basic: A=3, B=5, Sgn=0, tag=1, out_ready=1 -> exactly 4 cycles later out_valid=1, P_out=15, Tag_out=1.
REQ-039 Unsigned max: A=255, B=255, Sgn=0 -> P_out=65025 (16'hFE01).
REQ-040 Signed (ATM_SIGNED_EN defined):
- A=8'h80, B=8'h7F, Sgn=1 -> P_out=16'hC080 (-16256);
- A=8'hFF, B=8'hFF, Sgn=1 -> P_out=16'h0001.
REQ-041 Back-pressure:
- sequence: out_ready=0, stream tags 0..7 with in_valid=1;
- required: exactly 4 operations accepted, then in_ready=0 and P_out held;
- then raise out_ready: tags 0..3 emerge first, in order, then 4..7, with correct products.
REQ-042 Reset mid-operation:
- sequence: accept 3 operations, assert Reset low for 1 cycle before any result emerges;
- required: out_valid=0 immediately, no result ever produced for those 3, and a new operation after release completes with latency 4.
REQ-043 Mixed mode back-to-back: alternate Sgn=0 and Sgn=1 on A=8'hFF, B=8'h02 every cycle -> results alternate 16'h01FE and 16'hFFFE.
